reg_bank_wr_arbiter: RTL and testbench

- Shares the single register-bank write port (WE3/RA3/WD3) among N_REQ writeback requesters, e.g. ALU writeback and memory-load writeback.
- Uses a round-robin grant with a valid/ready handshake.
- Also provides a bank-clear sequencer that zeroes every register through the same port.
- Sits between the execute/memory writeback stages and reg_bank; its WE3/RA3/WD3 outputs connect directly to reg_bank.

---
 rtl/reg_bank_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/reg_bank_wr_arbiter.sv | 94 +++++++++
 tb/tb_reg_bank_wr_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared register-bank parameters and the write-arbiter FSM state type.
package reg_bank_pkg;
  localparam int WIDTH      = 32;
  localparam int TOTAL_REGS = 16;
  localparam int ADDR_W     = $clog2(TOTAL_REGS);

  typedef enum logic {IDLE, CLEAR} wr_arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// at or after ptr, searching upward with wrap.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_bank_wr_arbiter.sv
// Shares the reg_bank write port among N_REQ writeback requesters and runs
// a bank-clear sweep through the same port.
module reg_bank_wr_arbiter #(
  parameter int WIDTH      = reg_bank_pkg::WIDTH,
  parameter int TOTAL_REGS = reg_bank_pkg::TOTAL_REGS,
  parameter int N_REQ      = 2,
  localparam int ADDR_W    = $clog2(TOTAL_REGS),
  localparam int GW        = $clog2(N_REQ)
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [N_REQ-1:0]        REQ_VALID,
  input  logic [N_REQ*ADDR_W-1:0] REQ_ADDR,
  input  logic [N_REQ*WIDTH-1:0]  REQ_DATA,
  output logic [N_REQ-1:0]        REQ_READY,
  input  logic                    CLEAR_REQ,
  output logic                    BUSY,
  output logic [GW-1:0]           GRANT_ID,
  output logic                    WE3,
  output logic [ADDR_W-1:0]       RA3,
  output logic [WIDTH-1:0]        WD3
);
  import reg_bank_pkg::*;

  wr_arb_state_t     state_q;
  logic [GW-1:0]     ptr_q;
  logic [GW-1:0]     gid_d;
  logic [GW-1:0]     gid_q;
  logic [ADDR_W:0]   cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] ra_q;
  logic [WIDTH-1:0]  wd_q;
  logic [N_REQ-1:0]  grant;
  logic              accept;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (REQ_VALID),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // A clear request in IDLE wins over any pending writeback that cycle.
  assign REQ_READY = (state_q == IDLE && !CLEAR_REQ) ? grant : '0;
  assign accept    = |REQ_READY;

  always_comb begin
    gid_d = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) gid_d = GW'(i);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ra_q    <= '0;
      wd_q    <= '0;
      gid_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (CLEAR_REQ) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            we_q    <= 1'b0;
          end else if (accept) begin
            we_q  <= 1'b1;
            ra_q  <= REQ_ADDR[gid_d*ADDR_W +: ADDR_W];
            wd_q  <= REQ_DATA[gid_d*WIDTH +: WIDTH];
            gid_q <= gid_d;
            ptr_q <= (gid_d == GW'(N_REQ-1)) ? '0 : gid_d + 1'b1;
          end else begin
            we_q <= 1'b0;
          end
        end
        CLEAR: begin
          we_q  <= 1'b1;
          ra_q  <= cnt_q[ADDR_W-1:0];
          wd_q  <= '0;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == (ADDR_W+1)'(TOTAL_REGS-1)) state_q <= IDLE;
        end
      endcase
    end
  end

  assign BUSY     = (state_q == CLEAR);
  assign GRANT_ID = gid_q;
  assign WE3      = we_q;
  assign RA3      = ra_q;
  assign WD3      = wd_q;
endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// Directed bench for reg_bank_wr_arbiter with a behavioural reg_bank on WE3/RA3/WD3.
module tb_reg_bank_wr_arbiter;
  localparam int W = 32;
  localparam int R = 16;
  localparam int A = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [1:0]    REQ_VALID;
  logic [2*A-1:0] REQ_ADDR;
  logic [2*W-1:0] REQ_DATA;
  logic [1:0]    REQ_READY;
  logic          CLEAR_REQ;
  logic          BUSY;
  logic [0:0]    GRANT_ID;
  logic          WE3;
  logic [A-1:0]  RA3;
  logic [W-1:0]  WD3;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] mdl [R];

  reg_bank_wr_arbiter #(.WIDTH(W), .TOTAL_REGS(R), .N_REQ(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR),
    .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY), .CLEAR_REQ(CLEAR_REQ),
    .BUSY(BUSY), .GRANT_ID(GRANT_ID), .WE3(WE3), .RA3(RA3), .WD3(WD3)
  );

  always #5 CLK = ~CLK;

  // Downstream reg_bank: commits on the edge after WE3 is seen high.
  always @(posedge CLK) if (WE3) mdl[RA3] <= WD3;

  // Requesters must hold a pending request stable until it is accepted.
  logic [1:0]     pv = '0, pr = '0;
  logic [2*A-1:0] pa = '0;
  logic [2*W-1:0] pd = '0;
  always @(posedge CLK) begin
    if (RST_N)
      for (int i = 0; i < 2; i++)
        if (pv[i] && !pr[i])
          assert (REQ_VALID[i] && REQ_ADDR[i*A +: A] == pa[i*A +: A] &&
                  REQ_DATA[i*W +: W] == pd[i*W +: W])
            else $error("pending request %0d dropped or changed", i);
    pv <= RST_N ? REQ_VALID : '0;
    pr <= REQ_READY;
    pa <= REQ_ADDR;
    pd <= REQ_DATA;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [A-1:0] a0, input logic [A-1:0] a1,
                       input logic [W-1:0] d0, input logic [W-1:0] d1, input logic clr);
    REQ_VALID = v;
    REQ_ADDR  = {a1, a0};
    REQ_DATA  = {d1, d0};
    CLEAR_REQ = clr;
  endtask

  task automatic fill(input int base);
    for (int i = 0; i < R; i++) begin
      drive(2'b01, A'(i), '0, W'(base + i), '0, 1'b0);
      tick();
    end
    drive('0, '0, '0, '0, '0, 1'b0);
  endtask

  typedef struct {
    logic [1:0]   v;
    logic [A-1:0] a0, a1;
    logic [W-1:0] d0, d1;
    logic [1:0]   rdy;
    logic         we;
    logic         pay;
    logic [A-1:0] ra;
    logic [W-1:0] wd;
    logic         gid;
  } vec_t;

  vec_t vt [14];

  initial begin
    int busy_n, we_n, ra_bad, nz, rdy_bad;
    logic got;

    // Expected grant/write after each vector's edge; pointer starts at 0.
    vt[0]  = '{2'b01, 4'd3, 4'd0, 32'd100, 32'd0,  2'b01, 1'b1, 1'b1, 4'd3, 32'd100, 1'b0};
    vt[1]  = '{2'b11, 4'd1, 4'd2, 32'd10,  32'd20, 2'b10, 1'b1, 1'b1, 4'd2, 32'd20,  1'b1};
    vt[2]  = '{2'b11, 4'd1, 4'd2, 32'd10,  32'd20, 2'b01, 1'b1, 1'b1, 4'd1, 32'd10,  1'b0};
    vt[3]  = '{2'b11, 4'd1, 4'd2, 32'd10,  32'd20, 2'b10, 1'b1, 1'b1, 4'd2, 32'd20,  1'b1};
    vt[4]  = '{2'b11, 4'd1, 4'd2, 32'd10,  32'd20, 2'b01, 1'b1, 1'b1, 4'd1, 32'd10,  1'b0};
    vt[5]  = '{2'b10, 4'd0, 4'd2, 32'd0,   32'd20, 2'b10, 1'b1, 1'b1, 4'd2, 32'd20,  1'b1};
    vt[6]  = '{2'b00, 4'd0, 4'd0, 32'd0,   32'd0,  2'b00, 1'b0, 1'b0, 4'd0, 32'd0,   1'b0};
    vt[7]  = '{2'b10, 4'd0, 4'd7, 32'd0,   32'd70, 2'b10, 1'b1, 1'b1, 4'd7, 32'd70,  1'b1};
    vt[8]  = '{2'b10, 4'd0, 4'd8, 32'd0,   32'd80, 2'b10, 1'b1, 1'b1, 4'd8, 32'd80,  1'b1};
    vt[9]  = '{2'b10, 4'd0, 4'd9, 32'd0,   32'd90, 2'b10, 1'b1, 1'b1, 4'd9, 32'd90,  1'b1};
    vt[10] = '{2'b11, 4'd4, 4'd6, 32'd40,  32'd60, 2'b01, 1'b1, 1'b1, 4'd4, 32'd40,  1'b0};
    vt[11] = '{2'b11, 4'd4, 4'd6, 32'd40,  32'd60, 2'b10, 1'b1, 1'b1, 4'd6, 32'd60,  1'b1};
    vt[12] = '{2'b01, 4'd4, 4'd0, 32'd40,  32'd0,  2'b01, 1'b1, 1'b1, 4'd4, 32'd40,  1'b0};
    vt[13] = '{2'b00, 4'd0, 4'd0, 32'd0,   32'd0,  2'b00, 1'b0, 1'b0, 4'd0, 32'd0,   1'b0};

    RST_N = 1'b0;
    drive('0, '0, '0, '0, '0, 1'b0);
    tick(); tick();
    chk("rst_we", WE3, 0);   chk("rst_ra", RA3, 0);     chk("rst_wd", WD3, 0);
    chk("rst_gid", GRANT_ID, 0); chk("rst_busy", BUSY, 0); chk("rst_rdy", REQ_READY, 0);
    RST_N = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].v, vt[i].a0, vt[i].a1, vt[i].d0, vt[i].d1, 1'b0);
      #1;
      chk($sformatf("v%0d_rdy", i), REQ_READY, vt[i].rdy);
      tick();
      chk($sformatf("v%0d_we", i), WE3, vt[i].we);
      if (vt[i].pay) begin
        chk($sformatf("v%0d_ra", i), RA3, vt[i].ra);
        chk($sformatf("v%0d_wd", i), WD3, vt[i].wd);
        chk($sformatf("v%0d_gid", i), GRANT_ID, vt[i].gid);
      end
    end
    tick();
    chk("rd3", mdl[3], 100); chk("rd1", mdl[1], 10); chk("rd2", mdl[2], 20);
    chk("rd9", mdl[9], 90);  chk("rd4", mdl[4], 40); chk("rd6", mdl[6], 60);

    // Full clear; CLEAR_REQ held a few cycles into the sweep must not restart it.
    fill(100);
    drive('0, '0, '0, '0, '0, 1'b1);
    #1 chk("clr_rdy", REQ_READY, 0);
    tick();
    busy_n = 0; we_n = 0; ra_bad = 0;
    for (int k = 0; k < 24; k++) begin
      if (BUSY) busy_n++;
      if (WE3) begin
        if (RA3 != A'(we_n) || WD3 != 0) ra_bad++;
        we_n++;
      end
      CLEAR_REQ = (k < 3);
      tick();
    end
    chk("clr_busy_cycles", busy_n, 16);
    chk("clr_writes", we_n, 16);
    chk("clr_sweep_bad", ra_bad, 0);
    nz = 0;
    for (int i = 0; i < R; i++) if (mdl[i] != 0) nz++;
    chk("clr_nonzero_regs", nz, 0);

    // Clear collides with a pending write from requester 1.
    drive(2'b10, '0, 4'd5, '0, 32'd55, 1'b1);
    #1 chk("pend_rdy_at_clr", REQ_READY, 0);
    tick();
    CLEAR_REQ = 1'b0;
    rdy_bad = 0; got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (!BUSY) begin got = 1'b1; break; end
      if (REQ_READY != 0) rdy_bad++;
      tick();
    end
    chk("pend_busy_end", got, 1);
    chk("pend_rdy_during_clr", rdy_bad, 0);
    chk("pend_rdy_after", REQ_READY, 2'b10);
    tick();
    REQ_VALID = '0;
    chk("pend_we", WE3, 1); chk("pend_ra", RA3, 5); chk("pend_wd", WD3, 55);
    chk("pend_gid", GRANT_ID, 1);
    tick(); tick();
    chk("pend_reg5", mdl[5], 55);

    // Reset lands after the write of address 5 is on the port.
    fill(200);
    drive('0, '0, '0, '0, '0, 1'b1);
    tick();
    CLEAR_REQ = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (WE3 && RA3 == 5) begin got = 1'b1; break; end
      tick();
    end
    chk("mid_sixth_write", got, 1);
    RST_N = 1'b0;
    tick();
    chk("mid_we", WE3, 0); chk("mid_busy", BUSY, 0); chk("mid_ra", RA3, 0);
    RST_N = 1'b1;
    tick(); tick();
    chk("mid_we_after", WE3, 0);
    nz = 0;
    for (int i = 0; i < R; i++)
      if (mdl[i] != ((i < 6) ? 32'd0 : W'(200 + i))) nz++;
    chk("mid_regs_bad", nz, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
